// File: rtl/logic_gate_unit.sv
// Registered WIDTH-bit bitwise logic unit: opcode-selected gate function behind a
// valid/ready input, with a 2-entry in-order result buffer and a consumed-result counter.
module logic_gate_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_par,
  output logic             out_err,
  output logic [CNT_W-1:0] res_cnt
);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             ones;
    logic             par;
    logic             err;
  } entry_t;

  entry_t           newEntry;
  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             inReady_q;
  logic [CNT_W-1:0] resCnt_q;
  logic             push;
  logic             pop;

  always_comb begin
    newEntry     = '0;
    newEntry.err = 1'b0;
    case (in_op)
      3'd0:    newEntry.y = in_a & in_b;
      3'd1:    newEntry.y = in_a | in_b;
      3'd2:    newEntry.y = ~in_a;
      3'd3:    newEntry.y = ~(in_a & in_b);
      3'd4:    newEntry.y = ~(in_a | in_b);
      3'd5:    newEntry.y = in_a ^ in_b;
      3'd6:    newEntry.y = ~(in_a ^ in_b);
      default: begin
        newEntry.y   = '0;
        newEntry.err = 1'b1;
      end
    endcase
    newEntry.zero = (newEntry.y == '0);
    newEntry.ones = (newEntry.y == '1);
    newEntry.par  = ^newEntry.y;
  end

  assign push = in_valid && inReady_q;
  assign pop  = (count_q != 2'd0) && out_ready;

  // A push and a pop together can only happen at count 1, so the new beat becomes the head.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push && pop) begin
      head_d = newEntry;
    end else if (push) begin
      if (count_q == 2'd0) head_d = newEntry;
      else                 tail_d = newEntry;
      count_d = count_q + 2'd1;
    end else if (pop) begin
      if (count_q == 2'd2) head_d = tail_q;
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= 2'd0;
      inReady_q <= 1'b0;
      resCnt_q  <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      inReady_q <= (count_d < 2'd2);
      resCnt_q  <= resCnt_q + CNT_W'(pop);
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = (count_q != 2'd0);
  assign out_y     = head_q.y;
  assign out_zero  = head_q.zero;
  assign out_ones  = head_q.ones;
  assign out_par   = head_q.par;
  assign out_err   = head_q.err;
  assign res_cnt   = resCnt_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed and random stimulus for logic_gate_unit, checked against a queue-based
// reference model; a second instance with a 2-bit counter covers the wrap behaviour.
module tb_logic_gate_unit;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] y;
    logic         err;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_ready;

  logic         in_ready, out_valid, out_zero, out_ones, out_par, out_err;
  logic [W-1:0] out_y;
  logic [15:0]  res_cnt;

  logic         in_ready2, out_valid2, out_zero2, out_ones2, out_par2, out_err2;
  logic [W-1:0] out_y2;
  logic [1:0]   res_cnt2;

  int vectors = 0;
  int miscompares = 0;

  beat_t       mq[$];
  logic [W-1:0] mY;
  logic        mZero, mOnes, mPar, mErr, mInReady;
  int unsigned mCnt;

  always #5 clk = ~clk;

  logic_gate_unit #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero),
    .out_ones(out_ones), .out_par(out_par), .out_err(out_err), .res_cnt(res_cnt)
  );

  logic_gate_unit #(.WIDTH(W), .CNT_W(2)) dutWrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid2),
    .out_ready(out_ready), .out_y(out_y2), .out_zero(out_zero2),
    .out_ones(out_ones2), .out_par(out_par2), .out_err(out_err2), .res_cnt(res_cnt2)
  );

  function automatic beat_t refOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    beat_t r;
    r.err = 1'b0;
    case (op)
      3'd0:    r.y = a & b;
      3'd1:    r.y = a | b;
      3'd2:    r.y = ~a;
      3'd3:    r.y = ~(a & b);
      3'd4:    r.y = ~(a | b);
      3'd5:    r.y = a ^ b;
      3'd6:    r.y = ~(a ^ b);
      default: begin r.y = '0; r.err = 1'b1; end
    endcase
    return r;
  endfunction

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [31:0] wrapObs, wrapExp;
    compare({tag, ".in_ready"}, 32'(in_ready), 32'(mInReady));
    compare({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    compare({tag, ".out_y"}, 32'(out_y), 32'(mY));
    compare({tag, ".flags"}, {28'd0, out_zero, out_ones, out_par, out_err},
            {28'd0, mZero, mOnes, mPar, mErr});
    compare({tag, ".res_cnt"}, 32'(res_cnt), mCnt % 65536);
    wrapObs = {16'd0, in_ready2, out_valid2, out_zero2, out_ones2, out_par2, out_err2, res_cnt2, out_y2};
    wrapExp = {16'd0, mInReady, 1'(mq.size() > 0), mZero, mOnes, mPar, mErr, 2'(mCnt % 4), mY};
    compare({tag, ".wrap"}, wrapObs, wrapExp);
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic rdy, input string tag,
                               output bit accepted);
    bit push, pop;
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = rdy;
    push = v && mInReady;
    pop  = (mq.size() > 0) && rdy;
    @(posedge clk);
    #1;
    if (pop) begin
      mq.delete(0);
      mCnt++;
    end
    if (push) mq.push_back(refOp(op, a, b));
    if (mq.size() > 0) begin
      mY    = mq[0].y;
      mErr  = mq[0].err;
      mZero = (mY == '0);
      mOnes = (mY == '1);
      mPar  = ^mY;
    end
    mInReady = (mq.size() < 2);
    accepted = push;
    checkOutput(tag);
  endtask

  // Reset is asserted away from any edge so the asynchronous clear is observed directly.
  task automatic doReset(input string tag);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #2;
    mq.delete();
    mY = '0; mZero = 0; mOnes = 0; mPar = 0; mErr = 0;
    mCnt = 0; mInReady = 0;
    checkOutput({tag, ".asserted"});
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput({tag, ".released"});
    @(posedge clk);
    #1;
    mInReady = 1'b1;
    checkOutput({tag, ".firstEdge"});
  endtask

  initial begin
    logic [W-1:0] exp1 [7];
    bit acc;
    int nAcc;
    int tries;
    exp1 = '{8'h42, 8'hDB, 8'h3C, 8'hBD, 8'h24, 8'h99, 8'h66};
    rst_n = 1'b0; in_valid = 0; in_op = 0; in_a = 0; in_b = 0; out_ready = 0;
    #3;
    doReset("reset");

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, 3'(i), 8'hC3, 8'h5A, 1, "t1", acc);
      compare("t1.y_const", 32'(out_y), 32'(exp1[i]));
    end
    applyStimulus(0, 0, 0, 0, 1, "t1.drain", acc);
    compare("t1.res_cnt_const", 32'(res_cnt), 32'd7);

    applyStimulus(1, 3'd7, 8'hFF, 8'hFF, 1, "t2.rsv", acc);
    compare("t2.rsv_const", {28'd0, out_err, out_zero, out_par, 1'b0}, 32'b1100);
    applyStimulus(1, 3'd1, 8'h0F, 8'h30, 1, "t2.or", acc);
    compare("t2.err_clear", 32'(out_err), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, "t2.drain", acc);

    nAcc = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 3'd5, 8'(8'h11 * (i + 1)), 8'hA5, 0, "t3.stall", acc);
      if (acc) nAcc++;
    end
    compare("t3.accepted", 32'(nAcc), 32'd2);
    tries = 0;
    acc = 0;
    while (!acc && tries < 8) begin
      applyStimulus(1, 3'd5, 8'h33, 8'hA5, 1, "t3.release", acc);
      tries++;
    end
    compare("t3.third_taken", 32'(acc), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, "t3.drain", acc);

    applyStimulus(1, 3'd0, 8'hF0, 8'h3C, 0, "t4.fill", acc);
    applyStimulus(1, 3'd4, 8'h81, 8'h42, 1, "t4.pushpop", acc);
    compare("t4.pushpop_y", 32'(out_y), 32'h3C);
    applyStimulus(0, 0, 0, 0, 1, "t4.drain", acc);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                    8'($urandom), 1'($urandom_range(0, 3) != 0), "rand", acc);
    end

    applyStimulus(1, 3'd2, 8'h0F, 8'h00, 0, "t6.fill", acc);
    applyStimulus(1, 3'd6, 8'h12, 8'h34, 0, "t6.fill", acc);
    applyStimulus(1, 3'd1, 8'h55, 8'hAA, 0, "t6.full", acc);
    doReset("t6.reset");

    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                    8'($urandom), 1'($urandom_range(0, 1)), "rand2", acc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
